// File: rtl/deserializer_sipo.sv
// deserializer_sipo
//   Serial-in/parallel-out receiver for the far end of a PISO serializer link.
//   Bits arrive LSB first, qualified by bit_en, with sof marking word bit 0.
//   Each completed word is placed in a one-deep output register offered on a
//   valid/ready port. A sof in the middle of a word abandons the partial word
//   and reports frame_err. A word that completes while the output slot is still
//   full is dropped and sets the sticky overrun flag.
//
// Ports
//   clk        in   system clock, posedge
//   rst        in   asynchronous active-low reset
//   srl_in     in   serial data bit (valid when bit_en=1)
//   bit_en     in   bit strobe
//   sof        in   start of frame, current bit is word bit 0
//   data_out   out  received word, stable while data_valid=1
//   data_valid out  output word held, awaiting consumer
//   data_ready in   consumer accepts data_out on data_valid & data_ready
//   busy       out  word partially received
//   frame_err  out  one-cycle pulse, partial word abandoned by sof
//   overrun    out  sticky, completed word dropped because output was full
//   clr_err    in   synchronous clear of overrun
module deserializer_sipo #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  srl_in,
    input  logic                  bit_en,
    input  logic                  sof,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  overrun,
    input  logic                  clr_err
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q, overrun_d;

    logic [DATA_WIDTH-1:0] shifted;
    logic                  word_done;
    logic                  slot_free;

    // New bit enters at the top; after DATA_WIDTH bits the word is right-aligned.
    assign shifted = {srl_in, sreg_q[DATA_WIDTH-1:1]};

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        frame_err_d = 1'b0;
        word_done   = 1'b0;

        case (state_q)
            IDLE: begin
                // Bits without sof while idle belong to no frame and are ignored.
                if (bit_en && sof) begin
                    sreg_d  = shifted;
                    cnt_d   = CNT_W'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_en) begin
                    sreg_d = shifted;
                    if (sof) begin
                        // Resync: stale bits are flushed out by the new frame's shifts.
                        frame_err_d = 1'b1;
                        cnt_d       = CNT_W'(1);
                    end else if (cnt_q == LAST_CNT) begin
                        word_done = 1'b1;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The slot can take a new word if empty or being drained this same cycle.
    assign slot_free = !valid_q || data_ready;

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (clr_err) begin
            overrun_d = 1'b0;
        end

        if (word_done) begin
            if (slot_free) begin
                data_d  = shifted;
                valid_d = 1'b1;
            end else begin
                // Set takes priority over a simultaneous clear.
                overrun_d = 1'b1;
            end
        end else if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign busy       = (state_q == SHIFT);
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule
